// File: rtl/gerenciador_de_patterns_param.sv
// gerenciador_de_patterns_param: plays one of N_FASES stored command patterns, advancing on strobes
//   in : clk, rst_n (async, active-low), iniciar, abortar, trocar_comando, repetir,
//        selecao_fase/fim_da_lista (latched on start), esc_en/esc_fase/esc_end/esc_dado (memory write)
//   out: prox_comando, comando_valido, indice, fim_de_jogo, voltas
module gerenciador_de_patterns_param #(
  parameter int LARGURA_CMD = 4,
  parameter int PROFUNDIDADE = 16,
  parameter int N_FASES = 4,
  localparam int IW = $clog2(PROFUNDIDADE),
  localparam int FW = $clog2(N_FASES)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   iniciar,
  input  logic                   abortar,
  input  logic                   trocar_comando,
  input  logic                   repetir,
  input  logic [FW-1:0]          selecao_fase,
  input  logic [IW-1:0]          fim_da_lista,
  input  logic                   esc_en,
  input  logic [FW-1:0]          esc_fase,
  input  logic [IW-1:0]          esc_end,
  input  logic [LARGURA_CMD-1:0] esc_dado,
  output logic [LARGURA_CMD-1:0] prox_comando,
  output logic                   comando_valido,
  output logic [IW-1:0]          indice,
  output logic                   fim_de_jogo,
  output logic [7:0]             voltas
);
  typedef enum logic [1:0] {OCIOSO, JOGANDO, FIM} estado_t;
  estado_t estado_q, estado_d;
  logic [IW-1:0] indice_q, indice_d, lim_q, lim_d;
  logic [FW-1:0] fase_q, fase_d;
  logic [7:0] voltas_q, voltas_d;
  logic fim_q, fim_d;
  // flat memory addressed by {fase, entry}
  logic [LARGURA_CMD-1:0] mem_q [N_FASES*PROFUNDIDADE];
  logic [LARGURA_CMD-1:0] mem_d [N_FASES*PROFUNDIDADE];
  always_comb begin
    mem_d = mem_q;
    if (esc_en) mem_d[{esc_fase, esc_end}] = esc_dado;
  end
  always_comb begin
    estado_d = estado_q;
    indice_d = indice_q;
    voltas_d = voltas_q;
    fim_d = fim_q;
    fase_d = fase_q;
    lim_d = lim_q;
    if (abortar) begin
      estado_d = OCIOSO;
      indice_d = '0;
      voltas_d = '0;
      fim_d = 1'b0;
    end else if (iniciar && estado_q != JOGANDO) begin
      estado_d = JOGANDO;
      fase_d = selecao_fase;
      lim_d = fim_da_lista;
      indice_d = '0;
      voltas_d = '0;
      fim_d = 1'b0;
    end else if (trocar_comando && estado_q == JOGANDO) begin
      if (indice_q < lim_q) indice_d = indice_q + 1'b1;
      else if (repetir) begin
        indice_d = '0;
        voltas_d = (voltas_q == 8'hFF) ? voltas_q : voltas_q + 8'd1;
      end else begin
        estado_d = FIM;
        fim_d = 1'b1;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado_q <= OCIOSO;
      indice_q <= '0;
      voltas_q <= '0;
      fim_q <= 1'b0;
      fase_q <= '0;
      lim_q <= '0;
      for (int i = 0; i < N_FASES*PROFUNDIDADE; i++) mem_q[i] <= '0;
    end else begin
      estado_q <= estado_d;
      indice_q <= indice_d;
      voltas_q <= voltas_d;
      fim_q <= fim_d;
      fase_q <= fase_d;
      lim_q <= lim_d;
      mem_q <= mem_d;
    end
  end
  assign comando_valido = (estado_q == JOGANDO);
  assign prox_comando = comando_valido ? mem_q[{fase_q, indice_q}] : '0;
  assign indice = indice_q;
  assign fim_de_jogo = fim_q;
  assign voltas = voltas_q;
endmodule
